// File: rtl/piano_pkg.sv
// Shared types and entry-field layout for the piano record/playback path.
package piano_pkg;

    localparam int unsigned ENTRY_W  = 6;
    localparam int unsigned OCT_W    = 3;
    localparam int unsigned NOTE_W   = 3;
    localparam int unsigned OCT_MSB  = 5;
    localparam int unsigned OCT_LSB  = 3;
    localparam int unsigned NOTE_MSB = 2;
    localparam int unsigned NOTE_LSB = 0;

    localparam logic [NOTE_W-1:0] NOTE_REST = 3'd0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP
    } state_t;

endpackage

// File: rtl/playback_sequencer_if.sv
// Control, buffer-read and amplifier signals of the playback sequencer.
interface playback_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    import piano_pkg::*;

    logic                start;
    logic                stop;
    logic [ADDR_W:0]     rec_len;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ENTRY_W-1:0]  rd_data;
    logic [OCT_W-1:0]    octave;
    logic [NOTE_W-1:0]   note;
    logic                busy;
    logic                done;

    // Sequencer side: drives the read address and the amplifier.
    modport master (
        input  start, stop, rec_len, rd_data,
        output rd_addr, octave, note, busy, done
    );

    // Environment side: mode logic, buffer read port and amplifier.
    modport slave (
        output start, stop, rec_len, rd_data,
        input  rd_addr, octave, note, busy, done
    );

endinterface

// File: rtl/pb_timer.sv
// Loadable saturating down-counter; terminal count is reached at zero.
module pb_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc_c
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc_c = (count == '0);

endmodule

// File: rtl/playback_sequencer.sv
// Walks the recording buffer and presents each entry to the amplifier.
module playback_sequencer
    import piano_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned NOTE_CYCLES = 25000000,
    parameter int unsigned GAP_CYCLES  = 2500000
) (
    input  logic                 clk,
    input  logic                 rst,
    playback_sequencer_if.master bus
);

    localparam int unsigned MAX_CYC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [ADDR_W:0]  len_q;
    logic             last_c;
    logic             tmr_load_c;
    logic [CNT_W-1:0] tmr_val_c;
    logic             tmr_tc_c;

    // Current address is the final entry of the recording.
    assign last_c = (({1'b0, bus.rd_addr} + (ADDR_W+1)'(1)) == len_q);

    // Timer is reloaded on entry to PLAY (from LOAD) and on entry to GAP.
    always_comb begin
        tmr_load_c = 1'b0;
        tmr_val_c  = NOTE_LOAD;
        if (state == LOAD) begin
            tmr_load_c = 1'b1;
        end else if (state == PLAY && tmr_tc_c && !last_c && GAP_CYCLES != 0) begin
            tmr_load_c = 1'b1;
            tmr_val_c  = GAP_LOAD;
        end
    end

    pb_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .tc_c     (tmr_tc_c)
    );

    // Sequencer FSM with registered outputs; stop aborts from any busy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= '0;
            bus.rd_addr <= '0;
            bus.octave  <= '0;
            bus.note    <= NOTE_REST;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state != IDLE && bus.stop) begin
                state      <= IDLE;
                bus.octave <= '0;
                bus.note   <= NOTE_REST;
                bus.busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.stop) begin
                            len_q <= bus.rec_len;
                            if (bus.rec_len == '0) begin
                                bus.done <= 1'b1;
                            end else begin
                                bus.rd_addr <= '0;
                                bus.busy    <= 1'b1;
                                state       <= FETCH;
                            end
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        bus.octave <= bus.rd_data[OCT_MSB:OCT_LSB];
                        bus.note   <= bus.rd_data[NOTE_MSB:NOTE_LSB];
                        state      <= PLAY;
                    end
                    PLAY: begin
                        if (tmr_tc_c) begin
                            bus.octave <= '0;
                            bus.note   <= NOTE_REST;
                            if (last_c) begin
                                state    <= IDLE;
                                bus.busy <= 1'b0;
                                bus.done <= 1'b1;
                            end else if (GAP_CYCLES != 0) begin
                                state <= GAP;
                            end else begin
                                bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
                                state       <= FETCH;
                            end
                        end
                    end
                    GAP: begin
                        if (tmr_tc_c) begin
                            bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
                            state       <= FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
